delay_pulse_gen: RTL and testbench
==================================

DELAY_PULSE_GEN -- requirements
Module: delay_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of pulse count and emitted counter.
REQ-002 SHALL have parameter GAP_W, default 4, width of inter-pulse gap field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port io_cnt_valid  input  1  request offers a burst length.
REQ-006 SHALL have port io_cnt_ready  output  1  block can accept a request.
REQ-007 SHALL have port io_cnt_bits  input  CNT_W  number of pulses to emit.
REQ-008 SHALL have port io_gap  input  GAP_W  idle cycles between pulses, sampled at accept.
REQ-009 SHALL have port io_pulse  output  1  single-cycle enable pulse stream.
REQ-010 SHALL have port io_busy  output  1  high in RUN or GAP.
REQ-011 SHALL have port io_done  output  1  one-cycle strobe at burst end.
REQ-012 SHALL have port io_emitted  output  CNT_W  pulses emitted in current/last burst.

Function
REQ-013 SHALL implement states IDLE, RUN, GAP, DONE; io_cnt_ready=1 only in IDLE.
REQ-014 Accept occurs when io_cnt_valid && io_cnt_ready; SHALL latch remaining=io_cnt_bits, gap=io_gap, clear io_emitted to 0.
REQ-015 On accept with io_cnt_bits==0 SHALL go to DONE; zero pulses emitted.
REQ-016 On accept with io_cnt_bits!=0 SHALL go to RUN; first io_pulse in the cycle after accept (latency 1).
REQ-017 In RUN io_pulse SHALL be 1 for exactly that cycle; remaining decrements by 1, io_emitted increments by 1 (registered, visible next cycle).
REQ-018 From RUN: remaining==1 -> DONE; else latched gap==0 -> stay RUN (back-to-back pulses); else -> GAP with gap counter loaded to gap.
REQ-019 GAP SHALL hold io_pulse=0 for exactly gap cycles, then return to RUN.
REQ-020 DONE SHALL assert io_done for one cycle, then go to IDLE; io_done never coincides with io_pulse.
REQ-021 io_emitted SHALL hold its final value through IDLE until the next accept.
REQ-022 Counters SHALL never wrap: io_cnt_bits=2^CNT_W-1 emits exactly that many pulses.
REQ-023 io_cnt_bits/io_gap changes outside the accept cycle SHALL have no effect.
REQ-024 io_cnt_valid in non-IDLE states SHALL be ignored (not queued).

Reset
REQ-025 reset SHALL override all else, taking effect at the next rising edge, including mid-burst.
REQ-026 After reset: state IDLE, io_cnt_ready=1, io_pulse=0, io_busy=0, io_done=0, io_emitted=0, remaining=0, gap counter=0.
REQ-027 A request presented while reset is high SHALL NOT be accepted.

Configuration
REQ-028 Macro DELAY_PULSE_GEN_ABORT_EN SHALL, when defined, add port io_abort (input, 1).
REQ-029 With DELAY_PULSE_GEN_ABORT_EN: io_abort=1 in RUN or GAP SHALL go to DONE next cycle, no further pulses, io_emitted frozen at pulses already emitted; io_abort ignored in IDLE/DONE; abort in RUN cycle still emits that cycle's pulse.
REQ-030 Without DELAY_PULSE_GEN_ABORT_EN: no io_abort port; burst always runs to completion.

Verification
REQ-031 Accept cnt=3, gap=0 at cycle 0 -> io_pulse=1 cycles 1,2,3; io_done=1 cycle 4; io_emitted=3; ready=1 cycle 5.
REQ-032 Accept cnt=2, gap=2 at cycle 0 -> io_pulse at cycles 1 and 4; io_done cycle 5.
REQ-033 Accept cnt=0 -> no pulse; io_done=1 in cycle 1; io_emitted=0.
REQ-034 Accept cnt=10, gap=1; reset high at cycle 6 -> io_pulse=0, io_busy=0, io_emitted=0 from cycle 7; no io_done.
REQ-035 io_cnt_valid held high through a burst cnt=2, gap=0 with changing bits -> exactly 2 pulses, then new accept only at cycle 4 (IDLE).
REQ-036 (ABORT_EN) cnt=5, gap=0, io_abort=1 at cycle 3 -> pulses cycles 1-3, io_done cycle 4, io_emitted=3.

Source files
------------

// File: rtl/delay_pulse_gen.sv
// delay_pulse_gen
// Emits a burst of single-cycle enable pulses on io_pulse. A burst is
// requested with a valid/ready handshake carrying the pulse count
// (io_cnt_bits) and the number of idle cycles between pulses (io_gap).
// io_done strobes for one cycle when the burst ends, and io_emitted
// reports how many pulses the current or last burst produced.
//
// Optional feature: define DELAY_PULSE_GEN_ABORT_EN to add an io_abort
// input. It terminates a running burst early and keeps the count of
// pulses already issued.
//
// Outputs come straight from flops. Each one is computed from the
// next-state values, so the registered outputs line up with the state
// they describe.

module delay_pulse_gen #(
  parameter int CNT_W = 32,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_cnt_valid,
  output logic             io_cnt_ready,
  input  logic [CNT_W-1:0] io_cnt_bits,
  input  logic [GAP_W-1:0] io_gap,
`ifdef DELAY_PULSE_GEN_ABORT_EN
  input  logic             io_abort,
`endif
  output logic             io_pulse,
  output logic             io_busy,
  output logic             io_done,
  output logic [CNT_W-1:0] io_emitted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] C_GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] C_GAP_ONE  = GAP_W'(1);

  // Output flag decode for a given state; shared so that every
  // registered flag is derived from the same table.
  function automatic logic [3:0] state_flags(input state_t st);
    // {pulse, busy, done, ready}
    logic [3:0] flags;
    case (st)
      ST_IDLE: flags = 4'b0001;
      ST_RUN:  flags = 4'b1100;
      ST_GAP:  flags = 4'b0100;
      ST_DONE: flags = 4'b0010;
      default: flags = 4'b0001;
    endcase
    return flags;
  endfunction

  // State and datapath registers
  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_emitted;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  // Next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [GAP_W-1:0] w_gap_cnt_nxt;
  logic [CNT_W-1:0] w_emitted_nxt;
  logic [3:0]       w_flags_nxt;
  logic             w_accept;
  logic             w_abort;

`ifdef DELAY_PULSE_GEN_ABORT_EN
  assign w_abort = io_abort;
`else
  assign w_abort = 1'b0;
`endif

  // A request is taken only while idle. r_ready is high only in IDLE,
  // so requests arriving during a burst are dropped, not queued.
  assign w_accept = io_cnt_valid && r_ready;

  // Next-state logic: burst sequencing and counter updates
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_gap_nxt       = r_gap;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_emitted_nxt   = r_emitted;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_remaining_nxt = io_cnt_bits;
          w_gap_nxt       = io_gap;
          w_gap_cnt_nxt   = C_GAP_ZERO;
          w_emitted_nxt   = C_CNT_ZERO;
          if (io_cnt_bits == C_CNT_ZERO) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The pulse for this cycle is issued, even if an abort arrives.
        // remaining is at least 1 here, so the decrement cannot wrap.
        // emitted never exceeds the accepted count, so it cannot wrap.
        w_remaining_nxt = r_remaining - C_CNT_ONE;
        w_emitted_nxt   = r_emitted + C_CNT_ONE;
        if (w_abort) begin
          w_state_nxt = ST_DONE;
        end else if (r_remaining == C_CNT_ONE) begin
          w_state_nxt = ST_DONE;
        end else if (r_gap == C_GAP_ZERO) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = r_gap;
        end
      end
      ST_GAP: begin
        if (w_abort) begin
          w_state_nxt   = ST_DONE;
          w_gap_cnt_nxt = C_GAP_ZERO;
        end else if (r_gap_cnt <= C_GAP_ONE) begin
          w_state_nxt   = ST_RUN;
          w_gap_cnt_nxt = C_GAP_ZERO;
        end else begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = r_gap_cnt - C_GAP_ONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output flags follow the state being entered
  always_comb begin
    w_flags_nxt = state_flags(w_state_nxt);
  end

  // State, counters and registered outputs; reset takes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= C_CNT_ZERO;
      r_gap       <= C_GAP_ZERO;
      r_gap_cnt   <= C_GAP_ZERO;
      r_emitted   <= C_CNT_ZERO;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_gap       <= w_gap_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_emitted   <= w_emitted_nxt;
      r_pulse     <= w_flags_nxt[3];
      r_busy      <= w_flags_nxt[2];
      r_done      <= w_flags_nxt[1];
      r_ready     <= w_flags_nxt[0];
    end
  end

  assign io_pulse     = r_pulse;
  assign io_busy      = r_busy;
  assign io_done      = r_done;
  assign io_cnt_ready = r_ready;
  assign io_emitted   = r_emitted;

endmodule

// File: tb/tb_delay_pulse_gen.sv
// Directed bench for delay_pulse_gen. The expected per-cycle outputs are
// queued when each request is driven, then popped and compared on the
// falling edge of every checked cycle.
module tb_delay_pulse_gen;

  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic             clk;
  logic             reset;
  logic             io_cnt_valid;
  logic             io_cnt_ready;
  logic [CNT_W-1:0] io_cnt_bits;
  logic [GAP_W-1:0] io_gap;
  logic             io_pulse;
  logic             io_busy;
  logic             io_done;
  logic [CNT_W-1:0] io_emitted;
`ifdef DELAY_PULSE_GEN_ABORT_EN
  logic             io_abort;
`endif

  delay_pulse_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_cnt_valid (io_cnt_valid),
    .io_cnt_ready (io_cnt_ready),
    .io_cnt_bits  (io_cnt_bits),
    .io_gap       (io_gap),
`ifdef DELAY_PULSE_GEN_ABORT_EN
    .io_abort     (io_abort),
`endif
    .io_pulse     (io_pulse),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_emitted   (io_emitted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             p;
    logic             d;
    logic             b;
    logic             r;
    logic [CNT_W-1:0] e;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic push(input logic p, input logic d, input logic b,
                      input logic r, input int e);
    exp_t x;
    x.p = p; x.d = d; x.b = b; x.r = r; x.e = CNT_W'(e);
    q.push_back(x);
  endtask

  task automatic push_idle(input int e);
    push(1'b0, 1'b0, 1'b0, 1'b1, e);
  endtask

  task automatic cmp(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Advance to the next falling edge and check that cycle's outputs.
  task automatic check_cycle(input string tag);
    exp_t x;
    @(negedge clk);
    total++;
    assert (q.size() > 0) else begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (q.size() > 0) begin
      x = q.pop_front();
      cmp({tag, "_pulse"},   int'(io_pulse),     int'(x.p));
      cmp({tag, "_done"},    int'(io_done),      int'(x.d));
      cmp({tag, "_busy"},    int'(io_busy),      int'(x.b));
      cmp({tag, "_ready"},   int'(io_cnt_ready), int'(x.r));
      cmp({tag, "_emitted"}, int'(io_emitted),   int'(x.e));
    end else begin
      x = '0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    io_cnt_valid = 1'b0;
    io_cnt_bits  = '0;
    io_gap       = '0;
`ifdef DELAY_PULSE_GEN_ABORT_EN
    io_abort     = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);

    // A request offered while reset is high must not be taken.
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd5;
    push_idle(0); check_cycle("rst_req");
    io_cnt_valid = 1'b0; reset = 1'b0;
    push_idle(0); check_cycle("rst_idle");

    // cnt=3, gap=0: pulses in cycles 1..3, done in 4, ready in 5.
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd3; io_gap = 4'd0;
    push(1'b1, 1'b0, 1'b1, 1'b0, 0);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1);
    push(1'b1, 1'b0, 1'b1, 1'b0, 2);
    push(1'b0, 1'b1, 1'b0, 1'b0, 3);
    push_idle(3);
    check_cycle("b2b_c1");
    io_cnt_valid = 1'b0;
    for (int i = 0; i < 4; i++) check_cycle("b2b");

    // cnt=2, gap=2: pulses in cycles 1 and 4, done in 5. The inputs
    // change after the accept cycle, which must have no effect.
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd2; io_gap = 4'd2;
    push(1'b1, 1'b0, 1'b1, 1'b0, 0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1);
    push(1'b0, 1'b1, 1'b0, 1'b0, 2);
    push_idle(2);
    push_idle(2);
    check_cycle("gap_c1");
    io_cnt_valid = 1'b0; io_cnt_bits = 4'd7; io_gap = 4'd9;
    for (int i = 0; i < 6; i++) check_cycle("gap");

    // cnt=0: no pulse, done in cycle 1, emitted cleared to 0.
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd0; io_gap = 4'd3;
    push(1'b0, 1'b1, 1'b0, 1'b0, 0);
    push_idle(0);
    check_cycle("zero_c1");
    io_cnt_valid = 1'b0;
    check_cycle("zero_c2");

    // valid held high with changing bits: exactly 2 pulses, and the
    // next accept only happens from IDLE in cycle 4 (bits=1 there).
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd2; io_gap = 4'd0;
    push(1'b1, 1'b0, 1'b1, 1'b0, 0);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1);
    push(1'b0, 1'b1, 1'b0, 1'b0, 2);
    push_idle(2);
    push(1'b1, 1'b0, 1'b1, 1'b0, 0);
    push(1'b0, 1'b1, 1'b0, 1'b0, 1);
    push_idle(1);
    check_cycle("hold_c1"); io_cnt_bits = 4'd9;
    check_cycle("hold_c2"); io_cnt_bits = 4'd4;
    check_cycle("hold_c3"); io_cnt_bits = 4'd1;
    check_cycle("hold_c4");
    check_cycle("hold_c5"); io_cnt_valid = 1'b0;
    check_cycle("hold_c6");
    check_cycle("hold_c7");

    // Maximum count: 15 pulses with a 4-bit counter, no wrap.
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd15; io_gap = 4'd0;
    for (int i = 0; i < 15; i++) push(1'b1, 1'b0, 1'b1, 1'b0, i);
    push(1'b0, 1'b1, 1'b0, 1'b0, 15);
    push_idle(15);
    check_cycle("max_c1");
    io_cnt_valid = 1'b0;
    for (int i = 0; i < 16; i++) check_cycle("max");

    // cnt=10, gap=1, reset raised in cycle 6: idle from cycle 7, no done.
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd10; io_gap = 4'd1;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 1'b1, 1'b0, i);
      push(1'b0, 1'b0, 1'b1, 1'b0, i + 1);
    end
    push_idle(0);
    push_idle(0);
    push_idle(0);
    check_cycle("mrst_c1");
    io_cnt_valid = 1'b0;
    for (int i = 0; i < 5; i++) check_cycle("mrst");
    reset = 1'b1;
    check_cycle("mrst_c7");
    reset = 1'b0;
    check_cycle("mrst_c8");
    check_cycle("mrst_c9");

`ifdef DELAY_PULSE_GEN_ABORT_EN
    // cnt=5, gap=0, abort in cycle 3: pulses 1..3, done 4, emitted 3.
    io_cnt_valid = 1'b1; io_cnt_bits = 4'd5; io_gap = 4'd0;
    push(1'b1, 1'b0, 1'b1, 1'b0, 0);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1);
    push(1'b1, 1'b0, 1'b1, 1'b0, 2);
    push(1'b0, 1'b1, 1'b0, 1'b0, 3);
    push_idle(3);
    check_cycle("abt_c1");
    io_cnt_valid = 1'b0;
    check_cycle("abt_c2");
    check_cycle("abt_c3");
    io_abort = 1'b1;
    check_cycle("abt_c4");
    io_abort = 1'b0;
    check_cycle("abt_c5");
`endif

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain observed=%0d expected=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
